// File: rtl/sd_resp_pkg.sv
// Shared state encoding and block geometry for the sector-buffer responder.
package sd_resp_pkg;

  localparam int BLK_BYTES = 512;
  localparam int BLK_BITS  = 9;
  localparam logic [BLK_BITS-1:0] LAST_IDX = BLK_BITS'(BLK_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_MEM  = 3'd1,
    RD_PUT  = 3'd2,
    WR_ADDR = 3'd3,
    WR_LAT  = 3'd4,
    WR_MEM  = 3'd5,
    DONE    = 3'd6
  } sd_state_t;

endpackage

// File: rtl/sd_block_responder.sv
// Responder side of the sd_lba/sd_rd/sd_wr/sd_ack sector-buffer protocol,
// moving 512-byte blocks between the initiator's buffer and a RAM-disk image.
//
// state   | meaning
// IDLE    | waiting for sd_rd / sd_wr
// RD_MEM  | memory read of byte i outstanding (skipped on out-of-range)
// RD_PUT  | one-cycle strobe of byte i into the sector buffer
// WR_ADDR | sector buffer addressed at byte i
// WR_LAT  | buffer read latency; sample sd_buff_din at the end
// WR_MEM  | memory write of byte i outstanding
// DONE    | sd_ack low, waiting for the request lines to drop
module sd_block_responder
  import sd_resp_pkg::*;
#(
  parameter int MEM_AW = 25,
  parameter int LBA_W  = 32
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [LBA_W-1:0]  sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  input  logic [MEM_AW-1:0] img_base,
  input  logic [LBA_W-1:0]  img_blocks,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  localparam int OFS_W = LBA_W + BLK_BITS;
  localparam int SUM_W = (OFS_W > MEM_AW) ? OFS_W : MEM_AW;

  sd_state_t            state;
  logic [LBA_W-1:0]     lba_q;
  logic [BLK_BITS-1:0]  cnt;
  logic                 out_of_range;
  logic                 wr_step;
  logic                 last_byte;

  // Image offset wraps silently inside the MEM_AW-bit address space.
  function automatic logic [MEM_AW-1:0] byte_addr(input logic [MEM_AW-1:0] base,
                                                  input logic [LBA_W-1:0]  lba,
                                                  input logic [BLK_BITS-1:0] idx);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(base) + SUM_W'({lba, idx});
    return sum[MEM_AW-1:0];
  endfunction

  always_comb begin
    out_of_range = (sd_lba >= img_blocks);
    last_byte    = (cnt == LAST_IDX);
    wr_step      = ((state == WR_LAT) && err) || ((state == WR_MEM) && mem_ack);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      lba_q        <= '0;
      cnt          <= '0;
      sd_ack       <= 1'b0;
      sd_buff_addr <= '0;
      sd_buff_dout <= '0;
      sd_buff_wr   <= 1'b0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_din      <= '0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sd_rd || sd_wr) begin
            lba_q    <= sd_lba;
            cnt      <= '0;
            err      <= out_of_range;
            sd_ack   <= 1'b1;
            busy     <= 1'b1;
            mem_addr <= byte_addr(img_base, sd_lba, '0);
            if (sd_rd) begin
              mem_rd <= !out_of_range;
              state  <= RD_MEM;
            end else begin
              sd_buff_addr <= '0;
              state        <= WR_ADDR;
            end
          end
        end
        RD_MEM: begin
          // mem_rd is only ever high here, so a stray mem_ack elsewhere is ignored.
          if (err || mem_ack) begin
            mem_rd       <= 1'b0;
            sd_buff_addr <= cnt;
            sd_buff_dout <= err ? 8'h00 : mem_dout;
            sd_buff_wr   <= 1'b1;
            state        <= RD_PUT;
          end
        end
        RD_PUT: begin
          sd_buff_wr <= 1'b0;
          if (last_byte) begin
            sd_ack <= 1'b0;
            state  <= DONE;
          end else begin
            cnt      <= cnt + 1'b1;
            mem_addr <= byte_addr(img_base, lba_q, cnt + 1'b1);
            mem_rd   <= !err;
            state    <= RD_MEM;
          end
        end
        WR_ADDR: state <= WR_LAT;
        WR_LAT: begin
          if (!err) begin
            mem_din  <= sd_buff_din;
            mem_addr <= byte_addr(img_base, lba_q, cnt);
            mem_wr   <= 1'b1;
            state    <= WR_MEM;
          end
        end
        WR_MEM: if (mem_ack) mem_wr <= 1'b0;
        DONE: begin
          if (!sd_rd && !sd_wr) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (wr_step) begin
        if (last_byte) begin
          sd_ack <= 1'b0;
          state  <= DONE;
        end else begin
          cnt          <= cnt + 1'b1;
          sd_buff_addr <= cnt + 1'b1;
          state        <= WR_ADDR;
        end
      end
    end
  end

endmodule

// File: doc/sd_block_responder.md
Name: sd_block_responder

Overview:
- Responder end of the sector-buffer protocol (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*) whose initiator is the ZPU-side glue in the emu top.
- Services 512-byte block reads and writes against a disk image held in byte-addressed memory (SDRAM RAM-disk region) through a simple request/ack memory port.
- Lets a core mount an image without the HPS side of the protocol, and doubles as a bench model of it.

Parameters:
- MEM_AW, 25, byte address width of the memory port.
- LBA_W, 32, width of sd_lba and img_blocks.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sd_lba  in  LBA_W  sector number; sampled at request acceptance.
- sd_rd  in  1  read request (level).
- sd_wr  in  1  write request (level).
- sd_ack  out  1  high for the whole transfer; its falling edge signals completion.
- sd_buff_addr  out  9  byte index into the initiator's sector buffer.
- sd_buff_dout  out  8  read data written into the buffer.
- sd_buff_wr  out  1  one-cycle buffer write strobe.
- sd_buff_din  in  8  buffer data; valid one cycle after sd_buff_addr changes.
- img_base  in  MEM_AW  byte base address of the image.
- img_blocks  in  LBA_W  image size in sectors.
- mem_addr  out  MEM_AW  memory byte address.
- mem_rd  out  1  memory read request, held until mem_ack.
- mem_wr  out  1  memory write request, held until mem_ack.
- mem_din  out  8  memory write data.
- mem_dout  in  8  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- busy  out  1  FSM not in IDLE.
- err  out  1  last accepted request was out of range.

Behaviour:
- Reset (async, any state): FSM to IDLE; every output, the byte counter and captured LBA go to 0.
- IDLE: samples sd_rd and sd_wr.
  - If sd_rd is high (priority over sd_wr), latch sd_lba, clear counter i, set err = (sd_lba >= img_blocks), go to RD_MEM.
  - Else if sd_wr is high, do the same, go to WR_ADDR.
  - sd_ack rises the cycle after acceptance.
- Address rule: mem_addr = img_base + {lba, i[8:0]}, truncated to MEM_AW bits, wrap allowed.
- Read path:
  - RD_MEM: assert mem_rd, hold until mem_ack is sampled high; capture mem_dout; mem_rd drops the next cycle.
  - When err=1, skip memory entirely: data = 0, no mem_rd ever.
  - RD_PUT: sd_buff_addr=i, sd_buff_dout=data, sd_buff_wr=1 for exactly one cycle. If i==511 go to DONE, else i+1 and back to RD_MEM.
- Write path:
  - WR_ADDR: sd_buff_addr=i.
  - WR_LAT: one wait cycle for buffer read latency.
  - WR_MEM: mem_din=sd_buff_din (registered), assert mem_wr until mem_ack. If i==511 go to DONE, else i+1 and back to WR_ADDR.
  - When err=1, skip WR_MEM; no mem_wr ever, buffer addresses still walked.
- DONE: sd_ack=0. Stay until sd_rd==0 and sd_wr==0, then go to IDLE. A level-held request never retriggers a second transfer.
- mem_ack arriving while no request is outstanding is ignored.
- mem_rd and mem_wr are never high together.
- sd_rd or sd_wr changing mid-transfer has no effect.
- err stays valid until the next acceptance.
- img_blocks=0: every request is out of range.
- busy = (state != IDLE).

Decomposition:
- Package sd_resp_pkg: state enum (IDLE, RD_MEM, RD_PUT, WR_ADDR, WR_LAT, WR_MEM, DONE) and constants BLK_BYTES=512, BLK_BITS=9.
- Single module; no sub-module warranted.

Test Plan:
- Read, in range: img_base=0x1000, img_blocks=8, memory byte = low address byte, sd_rd with lba=3, mem_ack 1 cycle after request.
  - mem_rd addresses 0x1600..0x17FF in order.
  - 512 sd_buff_wr pulses at addresses 0..511 with dout=0x00..0xFF repeating.
  - sd_ack rises 1 cycle after acceptance and falls after the last strobe; err=0.
- Write, in range: preload the buffer model with i^0x5A, sd_wr with lba=0, mem_ack delayed 4 cycles.
  - mem_wr held exactly until each ack.
  - Memory 0x1000..0x11FF holds i^0x5A.
  - Buffer is read at each address before the matching mem_wr.
- Out of range: sd_rd with lba=8 (equal to img_blocks) -> 512 zero writes to the buffer, mem_rd never asserted, err=1.
  - A following sd_wr with lba=9 -> no mem_wr, err=1.
- Reset mid-read: assert reset_n low at byte 100 -> all outputs 0 immediately.
  - After release, a new read of lba=1 completes fully and correctly.
- Held request / priority:
  - sd_rd and sd_wr both high -> read is performed.
  - Requester keeps sd_rd high after sd_ack falls -> no second transfer; a new transfer starts only after sd_rd drops and is raised again.
